id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage: registers decoded instruction fields from ID and presents ALU operands `a`, `b` and `ALUSel` to the EX-stage ALU. Contains operand forwarding from MEM and WB, load-use hazard detection, stall/flush control and valid/ready handshakes on both sides. Sits between decode/register-file read and the combinational ALU; its outputs also carry store data and control to EX/MEM.

## Interface
- `XLEN`, 32, datapath width
- `RAW`, 5, register address width
- `clk` in 1, clock
- `rst` in 1, reset, synchronous, active-high
- `id_valid` in 1, ID offers an instruction
- `id_ready` out 1, stage accepts the ID instruction this cycle
- `id_pc` in XLEN, instruction PC
- `id_rs1_addr`, `id_rs2_addr` in RAW, source registers
- `id_rs1_data`, `id_rs2_data` in XLEN, register-file read data; write-through of same-cycle WB write
- `id_imm` in XLEN, sign-extended immediate
- `id_rd_addr` in RAW, destination register
- `id_alu_sel` in 5, ALU function (`Riscv_defs.svh` encoding)
- `id_src1_pc`, `id_src2_imm` in 1, select PC as `a` / imm as `b`
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1, control
- `flush` in 1, branch redirect from EX
- `ex_ready` in 1, downstream accepts
- `mem_valid`, `mem_reg_write` in 1; `mem_rd_addr` in RAW; `mem_result` in XLEN, MEM-stage producer
- `wb_valid`, `wb_reg_write` in 1; `wb_rd_addr` in RAW; `wb_result` in XLEN, WB-stage producer
- `ex_valid` out 1, EX holds a live instruction
- `ex_alu_a`, `ex_alu_b` out XLEN, ALU operands (forwarded)
- `ex_alu_sel` out 5, ALU function
- `ex_store_data` out XLEN, forwarded rs2
- `ex_pc` out XLEN; `ex_rd_addr` out RAW; `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1

## Operation
- Register holds: valid, pc, rs1/rs2 addr+data, imm, rd, alu_sel, src selects, control.
- Reset: `ex_valid`=0, all payload 0, `ex_alu_sel`=`ALUNoP`; `id_ready`=1 after reset deasserts.
- Forwarding (combinational on registered fields): rs1/rs2 take `mem_result` if `mem_valid && mem_reg_write && mem_rd_addr==rs && rs!=0`; else `wb_result` under same test on WB; else registered data. MEM beats WB. x0 never forwarded.
- `ex_alu_a` = src1_pc ? pc : fwd_rs1; `ex_alu_b` = src2_imm ? imm : fwd_rs2; `ex_store_data` = fwd_rs2 always.
- Load-use: `ex_valid && ex_mem_read && ex_rd_addr!=0` matching `id_rs1_addr` or `id_rs2_addr` → stall: `id_ready`=0, bubble (`ex_valid`=0, control 0, `ALUNoP`) loaded if `ex_ready`.
- Hold: `ex_ready`=0 → register keeps instruction, `id_ready`=0; rs1/rs2 data fields reload with forwarded values each held cycle so a producer retiring during the hold is not lost.
- Flush (highest priority): next cycle `ex_valid`=0; `id_ready`=1 and the ID instruction is dropped. Flush overrides hold and load-use stall.
- Advance: `id_valid && id_ready && ex_ready && !flush` → capture ID fields, `ex_valid`=1. `!id_valid` with `ex_ready` → bubble.

## Timing
- ID→EX latency 1 cycle; operands combinational from register + bypass buses, no extra cycle.
- `id_ready` combinational from registered EX fields, `ex_ready`, `flush`, ID rs addresses.
- Load-use costs exactly 1 bubble; a second dependent instruction then forwards from MEM.
- Simultaneous `flush` and `rst`: reset wins, identical result.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding and 1-cycle load-use stall as above.
- Undefined: no bypass muxes; operands are registered data only. Stall (`id_ready`=0, bubble) while any of EX (`ex_valid && ex_reg_write`) or MEM (`mem_valid && mem_reg_write`) has nonzero rd matching an ID source; WB conflict resolved by register-file write-through. Hold-refresh reloads from `id_*_data` inputs irrelevant; fields stay.

## Structure
- Package `riscv_pipe_pkg`: `id_ex_t` struct of registered fields, `fwd_sel_e` enum {FWD_REG, FWD_MEM, FWD_WB}, `BUBBLE` constant.
- ALU encodings stay in `Riscv_defs.svh`.
- Sub-module `fwd_unit`: forwarding select + hazard compare (both macro variants).

## Test plan
- Back-to-back `addi x1,x0,5`; `add x2,x1,x1` → second cycle `ex_alu_a`=`ex_alu_b`=5 via MEM forward, no stall.
- `lw x3` then `add x4,x3,x0` → `id_ready`=0 one cycle, one bubble, then `ex_alu_a`=`mem_result` (e.g. 0xDEADBEEF).
- MEM and WB both write x5 (7 vs 9), EX reads x5 → `ex_alu_a`=7.
- Producer rd=x0 with result 0x1234 → consumer of x0 sees 0.
- `flush` with `ex_ready`=0 and `id_valid`=1 → next cycle `ex_valid`=0, `id_ready` was 1.
- `ex_ready`=0 for 3 cycles while WB retires x6=0x55 → on release `ex_alu_a`=0x55; macro off: same program shows 2 stall cycles, identical results.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pipe_pkg
// Brief  : Shared types for the ID/EX pipeline register and its bypass logic.
// Rev    : 1.0  initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int PIPE_RAW  = 5;

    // Mirrors the ALU function codes of Riscv_defs.svh used by this stage.
    localparam logic [4:0] ALUAdd = 5'd0;
    localparam logic [4:0] ALUNoP = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_RAW-1:0]  rs1_addr;
        logic [PIPE_RAW-1:0]  rs2_addr;
        logic [PIPE_XLEN-1:0] rs1_data;
        logic [PIPE_XLEN-1:0] rs2_data;
        logic [PIPE_XLEN-1:0] imm;
        logic [PIPE_RAW-1:0]  rd_addr;
        logic [4:0]           alu_sel;
        logic                 src1_pc;
        logic                 src2_imm;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '{
        valid:     1'b0,
        pc:        '0,
        rs1_addr:  '0,
        rs2_addr:  '0,
        rs1_data:  '0,
        rs2_data:  '0,
        imm:       '0,
        rd_addr:   '0,
        alu_sel:   ALUNoP,
        src1_pc:   1'b0,
        src2_imm:  1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage_if
// Brief  : ID-side handshake, MEM/WB bypass buses and EX-side outputs.
// Rev    : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RAW-1:0]  id_rs1_addr;
    logic [RAW-1:0]  id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RAW-1:0]  id_rd_addr;
    logic [4:0]      id_alu_sel;
    logic            id_src1_pc;
    logic            id_src2_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            flush;
    logic            ex_ready;
    logic            mem_valid;
    logic            mem_reg_write;
    logic [RAW-1:0]  mem_rd_addr;
    logic [XLEN-1:0] mem_result;
    logic            wb_valid;
    logic            wb_reg_write;
    logic [RAW-1:0]  wb_rd_addr;
    logic [XLEN-1:0] wb_result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic [4:0]      ex_alu_sel;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [RAW-1:0]  ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_rd_addr, id_alu_sel, id_src1_pc, id_src2_imm,
               id_reg_write, id_mem_read, id_mem_write, flush, ex_ready,
               mem_valid, mem_reg_write, mem_rd_addr, mem_result,
               wb_valid, wb_reg_write, wb_rd_addr, wb_result,
        input  id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data,
               ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_rd_addr, id_alu_sel, id_src1_pc, id_src2_imm,
               id_reg_write, id_mem_read, id_mem_write, flush, ex_ready,
               mem_valid, mem_reg_write, mem_rd_addr, mem_result,
               wb_valid, wb_reg_write, wb_rd_addr, wb_result,
        output id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data,
               ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module : fwd_unit
// Brief  : Operand bypass selection and ID-side hazard compare.
//          ID_EX_FORWARD_EN selects bypassing with a load-use stall; without it
//          ID stalls on any in-flight EX/MEM producer.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_unit
    import riscv_pipe_pkg::*;
#(
    parameter int RAW = PIPE_RAW
) (
    input  logic           ex_valid_i,
    input  logic           ex_reg_write_i,
    input  logic           ex_mem_read_i,
    input  logic [RAW-1:0] ex_rd_addr_i,
    input  logic [RAW-1:0] ex_rs1_addr_i,
    input  logic [RAW-1:0] ex_rs2_addr_i,
    input  logic [RAW-1:0] id_rs1_addr_i,
    input  logic [RAW-1:0] id_rs2_addr_i,
    input  logic           mem_valid_i,
    input  logic           mem_reg_write_i,
    input  logic [RAW-1:0] mem_rd_addr_i,
    input  logic           wb_valid_i,
    input  logic           wb_reg_write_i,
    input  logic [RAW-1:0] wb_rd_addr_i,
    output fwd_sel_e       rs1_sel_o,
    output fwd_sel_e       rs2_sel_o,
    output logic           stall_o
);

    // x0 is hard-wired, so a producer targeting it never matches.
    function automatic logic hits(input logic [RAW-1:0] rd, input logic [RAW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

    logic w_mem_live;
    assign w_mem_live = mem_valid_i && mem_reg_write_i;

`ifdef ID_EX_FORWARD_EN
    logic w_wb_live;
    assign w_wb_live = wb_valid_i && wb_reg_write_i;

    function automatic fwd_sel_e pick(input logic [RAW-1:0] rs,
                                      input logic           mem_live,
                                      input logic [RAW-1:0] mem_rd,
                                      input logic           wb_live,
                                      input logic [RAW-1:0] wb_rd);
        if (mem_live && hits(mem_rd, rs)) begin
            return FWD_MEM;
        end
        if (wb_live && hits(wb_rd, rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    assign rs1_sel_o = pick(ex_rs1_addr_i, w_mem_live, mem_rd_addr_i, w_wb_live, wb_rd_addr_i);
    assign rs2_sel_o = pick(ex_rs2_addr_i, w_mem_live, mem_rd_addr_i, w_wb_live, wb_rd_addr_i);

    // Only a load in EX cannot be bypassed in time.
    assign stall_o = ex_valid_i && ex_mem_read_i &&
                     (hits(ex_rd_addr_i, id_rs1_addr_i) || hits(ex_rd_addr_i, id_rs2_addr_i));

    logic w_unused;
    assign w_unused = ex_reg_write_i;
`else
    logic w_ex_hit;
    logic w_mem_hit;

    assign rs1_sel_o = FWD_REG;
    assign rs2_sel_o = FWD_REG;

    // WB is covered by register-file write-through, so only EX and MEM block.
    assign w_ex_hit  = ex_valid_i && ex_reg_write_i &&
                       (hits(ex_rd_addr_i, id_rs1_addr_i) || hits(ex_rd_addr_i, id_rs2_addr_i));
    assign w_mem_hit = w_mem_live &&
                       (hits(mem_rd_addr_i, id_rs1_addr_i) || hits(mem_rd_addr_i, id_rs2_addr_i));
    assign stall_o   = w_ex_hit || w_mem_hit;

    logic w_unused;
    assign w_unused = ^{ex_mem_read_i, ex_rs1_addr_i, ex_rs2_addr_i,
                        wb_valid_i, wb_reg_write_i, wb_rd_addr_i};
`endif

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register presenting forwarded ALU operands to EX,
//          with load-use/hazard stall, hold and flush. Bypass network enabled
//          by ID_EX_FORWARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN,
    parameter int RAW  = PIPE_RAW
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    id_ex_t          w_id_fields;
    fwd_sel_e        w_rs1_sel;
    fwd_sel_e        w_rs2_sel;
    logic            w_hazard;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    fwd_unit #(
        .RAW (RAW)
    ) u_fwd_unit (
        .ex_valid_i      (ex_q.valid),
        .ex_reg_write_i  (ex_q.reg_write),
        .ex_mem_read_i   (ex_q.mem_read),
        .ex_rd_addr_i    (ex_q.rd_addr),
        .ex_rs1_addr_i   (ex_q.rs1_addr),
        .ex_rs2_addr_i   (ex_q.rs2_addr),
        .id_rs1_addr_i   (bus.id_rs1_addr),
        .id_rs2_addr_i   (bus.id_rs2_addr),
        .mem_valid_i     (bus.mem_valid),
        .mem_reg_write_i (bus.mem_reg_write),
        .mem_rd_addr_i   (bus.mem_rd_addr),
        .wb_valid_i      (bus.wb_valid),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_rd_addr_i    (bus.wb_rd_addr),
        .rs1_sel_o       (w_rs1_sel),
        .rs2_sel_o       (w_rs2_sel),
        .stall_o         (w_hazard)
    );

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        case (w_rs1_sel)
            FWD_MEM: w_fwd_rs1 = bus.mem_result;
            FWD_WB:  w_fwd_rs1 = bus.wb_result;
            default: w_fwd_rs1 = ex_q.rs1_data;
        endcase
        case (w_rs2_sel)
            FWD_MEM: w_fwd_rs2 = bus.mem_result;
            FWD_WB:  w_fwd_rs2 = bus.wb_result;
            default: w_fwd_rs2 = ex_q.rs2_data;
        endcase
    end
`else
    assign w_fwd_rs1 = ex_q.rs1_data;
    assign w_fwd_rs2 = ex_q.rs2_data;

    logic w_unused;
    assign w_unused = ^{bus.mem_result, bus.wb_result, w_rs1_sel, w_rs2_sel};
`endif

    always_comb begin
        w_id_fields           = BUBBLE;
        w_id_fields.valid     = 1'b1;
        w_id_fields.pc        = bus.id_pc;
        w_id_fields.rs1_addr  = bus.id_rs1_addr;
        w_id_fields.rs2_addr  = bus.id_rs2_addr;
        w_id_fields.rs1_data  = bus.id_rs1_data;
        w_id_fields.rs2_data  = bus.id_rs2_data;
        w_id_fields.imm       = bus.id_imm;
        w_id_fields.rd_addr   = bus.id_rd_addr;
        w_id_fields.alu_sel   = bus.id_alu_sel;
        w_id_fields.src1_pc   = bus.id_src1_pc;
        w_id_fields.src2_imm  = bus.id_src2_imm;
        w_id_fields.reg_write = bus.id_reg_write;
        w_id_fields.mem_read  = bus.id_mem_read;
        w_id_fields.mem_write = bus.id_mem_write;
    end

    // A flush always frees ID: the offered instruction is on the wrong path.
    assign bus.id_ready = bus.flush || (bus.ex_ready && !w_hazard);

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = BUBBLE;
        end else if (!bus.ex_ready) begin
`ifdef ID_EX_FORWARD_EN
            // Capture bypass values now; the producer may retire before release.
            ex_d.rs1_data = w_fwd_rs1;
            ex_d.rs2_data = w_fwd_rs2;
`endif
        end else if (w_hazard || !bus.id_valid) begin
            ex_d = BUBBLE;
        end else begin
            ex_d = w_id_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_a      = ex_q.src1_pc  ? ex_q.pc  : w_fwd_rs1;
    assign bus.ex_alu_b      = ex_q.src2_imm ? ex_q.imm : w_fwd_rs2;
    assign bus.ex_alu_sel    = ex_q.alu_sel;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_stage
// Brief  : Directed bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
    import riscv_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    id_ex_stage_if #(.XLEN(32), .RAW(5)) bus ();

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic id_drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic [4:0] rd, input logic s1pc, input logic s2imm,
                            input logic rw, input logic mr);
        bus.id_valid     = 1'b1;
        bus.id_pc        = pc;
        bus.id_rs1_addr  = rs1;
        bus.id_rs2_addr  = rs2;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_rd_addr   = rd;
        bus.id_alu_sel   = ALUAdd;
        bus.id_src1_pc   = s1pc;
        bus.id_src2_imm  = s2imm;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = 1'b0;
    endtask

    task automatic id_idle;
        bus.id_valid    = 1'b0;
        bus.id_rs1_addr = 5'd0;
        bus.id_rs2_addr = 5'd0;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] res);
        bus.mem_valid     = v;
        bus.mem_reg_write = rw;
        bus.mem_rd_addr   = rd;
        bus.mem_result    = res;
    endtask

    task automatic set_wb(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] res);
        bus.wb_valid     = v;
        bus.wb_reg_write = rw;
        bus.wb_rd_addr   = rd;
        bus.wb_result    = res;
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        id_drive(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_idle;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(bus.ex_valid), 32'd0);
        chk("rst_alu_sel", 32'(bus.ex_alu_sel), 32'(ALUNoP));
        chk("rst_pc",      bus.ex_pc, 32'h0);
        chk("rst_alu_a",   bus.ex_alu_a, 32'h0);
        chk("rst_store",   bus.ex_store_data, 32'h0);
        chk("rst_rw",      32'(bus.ex_reg_write), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_id_ready", 32'(bus.id_ready), 32'd1);

        // addi x1,x0,5 ; add x2,x1,x1
        id_drive(32'h100, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t1_addi_ready", 32'(bus.id_ready), 32'd1);
        tick;
        chk("t1_addi_valid", 32'(bus.ex_valid), 32'd1);
        chk("t1_addi_b",     bus.ex_alu_b, 32'h5);
        chk("t1_addi_pc",    bus.ex_pc, 32'h100);
        id_drive(32'h104, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("t1_add_ready", 32'(bus.id_ready), 32'd1);
        tick;
        set_mem(1'b1, 1'b1, 5'd1, 32'h5);
        #1;
`else
        chk("t1_add_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b1, 1'b1, 5'd1, 32'h5);
        #1;
        chk("t1_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("t1_stall2_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd1, 32'h5);
        id_drive(32'h104, 5'd1, 5'd1, 32'h5, 32'h5, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t1_wt_ready", 32'(bus.id_ready), 32'd1);
        tick;
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
`endif
        chk("t1_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("t1_add_a",     bus.ex_alu_a, 32'h5);
        chk("t1_add_b",     bus.ex_alu_b, 32'h5);
        chk("t1_add_store", bus.ex_store_data, 32'h5);
        chk("t1_add_rd",    32'(bus.ex_rd_addr), 32'd2);

        // lw x3,0(x0) ; add x4,x3,x0
        id_idle;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        chk("t2_drain_valid", 32'(bus.ex_valid), 32'd0);
        id_drive(32'h200, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t2_lw_ready", 32'(bus.id_ready), 32'd1);
        tick;
        chk("t2_lw_memread", 32'(bus.ex_mem_read), 32'd1);
        id_drive(32'h204, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t2_lu_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
        #1;
        chk("t2_bubble_valid",   32'(bus.ex_valid), 32'd0);
        chk("t2_bubble_sel",     32'(bus.ex_alu_sel), 32'(ALUNoP));
        chk("t2_bubble_memread", 32'(bus.ex_mem_read), 32'd0);
`ifdef ID_EX_FORWARD_EN
        chk("t2_after_ready", 32'(bus.id_ready), 32'd1);
        tick;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
        #1;
`else
        chk("t2_after_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
        id_drive(32'h204, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t2_wt_ready", 32'(bus.id_ready), 32'd1);
        tick;
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
`endif
        chk("t2_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("t2_add_a",     bus.ex_alu_a, 32'hDEADBEEF);

        // MEM (7) and WB (9) both write x5 while EX reads x5
        id_idle;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        tick;
        id_drive(32'h300, 5'd5, 5'd5, 32'h11, 32'h22, 32'h40, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t3_ready", 32'(bus.id_ready), 32'd1);
        tick;
        id_idle;
        set_mem(1'b1, 1'b1, 5'd5, 32'h7);
        set_wb(1'b1, 1'b1, 5'd5, 32'h9);
        #1;
        chk("t3_b_imm", bus.ex_alu_b, 32'h40);
`ifdef ID_EX_FORWARD_EN
        chk("t3_a_mem_wins", bus.ex_alu_a, 32'h7);
        chk("t3_store_mem",  bus.ex_store_data, 32'h7);
`else
        chk("t3_a_reg",      bus.ex_alu_a, 32'h11);
        chk("t3_store_reg",  bus.ex_store_data, 32'h22);
`endif
        set_mem(1'b0, 1'b1, 5'd5, 32'h7);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("t3_a_mem_invalid", bus.ex_alu_a, 32'h9);
`else
        chk("t3_a_mem_invalid", bus.ex_alu_a, 32'h11);
`endif
        set_mem(1'b1, 1'b0, 5'd5, 32'h7);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("t3_a_mem_nowrite", bus.ex_alu_a, 32'h9);
`else
        chk("t3_a_mem_nowrite", bus.ex_alu_a, 32'h11);
`endif
        set_mem(1'b1, 1'b1, 5'd6, 32'h7);
        set_wb(1'b1, 1'b1, 5'd6, 32'h9);
        #1;
        chk("t3_a_no_match", bus.ex_alu_a, 32'h11);

        // producers writing x0 with 0x1234; consumer reads x0
        set_mem(1'b1, 1'b1, 5'd0, 32'h1234);
        set_wb(1'b1, 1'b1, 5'd0, 32'h1234);
        id_drive(32'h400, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t4_ready", 32'(bus.id_ready), 32'd1);
        tick;
        chk("t4_a_x0",     bus.ex_alu_a, 32'h0);
        chk("t4_store_x0", bus.ex_store_data, 32'h0);

        // PC-relative operand, then hold, then flush during hold
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        id_drive(32'h500, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1000, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t5_ready", 32'(bus.id_ready), 32'd1);
        tick;
        id_drive(32'h504, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t5_a_pc",  bus.ex_alu_a, 32'h500);
        chk("t5_b_imm", bus.ex_alu_b, 32'h1000);
        bus.ex_ready = 1'b0;
        #1;
        chk("t5_hold_ready", 32'(bus.id_ready), 32'd0);
        tick;
        chk("t5_hold_pc",    bus.ex_pc, 32'h500);
        chk("t5_hold_valid", 32'(bus.ex_valid), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("t5_flush_ready", 32'(bus.id_ready), 32'd1);
        tick;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        id_idle;
        #1;
        chk("t5_flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("t5_flush_rw",    32'(bus.ex_reg_write), 32'd0);
        chk("t5_flush_pc",    bus.ex_pc, 32'h0);

        // addi x6,x0,0x55 ; add x7,x6,x0 ; EX held 3 cycles while x6 retires
        id_drive(32'h600, 5'd0, 5'd0, 32'h0, 32'h0, 32'h55, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t6_addi_ready", 32'(bus.id_ready), 32'd1);
        tick;
        id_drive(32'h604, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("t6_add_ready", 32'(bus.id_ready), 32'd1);
        tick;
`else
        chk("t6_stall1_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b1, 1'b1, 5'd6, 32'h55);
        #1;
        chk("t6_stall2_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd6, 32'h55);
        id_drive(32'h604, 5'd6, 5'd0, 32'h55, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t6_wt_ready", 32'(bus.id_ready), 32'd1);
        tick;
`endif
        id_idle;
        bus.ex_ready = 1'b0;
        set_mem(1'b1, 1'b1, 5'd6, 32'h55);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t6_h1_a",     bus.ex_alu_a, 32'h55);
        chk("t6_h1_ready", 32'(bus.id_ready), 32'd0);
        tick;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd6, 32'h55);
        #1;
        chk("t6_h2_a",     bus.ex_alu_a, 32'h55);
        chk("t6_h2_valid", 32'(bus.ex_valid), 32'd1);
        tick;
        set_wb(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t6_h3_a",  bus.ex_alu_a, 32'h55);
        chk("t6_h3_pc", bus.ex_pc, 32'h604);
        tick;
        bus.ex_ready = 1'b1;
        #1;
        chk("t6_rel_a",     bus.ex_alu_a, 32'h55);
        chk("t6_rel_ready", 32'(bus.id_ready), 32'd1);

        // reset and flush together
        id_drive(32'h700, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        rst       = 1'b1;
        bus.flush = 1'b1;
        tick;
        rst       = 1'b0;
        bus.flush = 1'b0;
        id_idle;
        #1;
        chk("t7_valid",   32'(bus.ex_valid), 32'd0);
        chk("t7_alu_sel", 32'(bus.ex_alu_sel), 32'(ALUNoP));
        chk("t7_pc",      bus.ex_pc, 32'h0);
        chk("t7_ready",   32'(bus.id_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
